// File: rtl/mmm_serial_core.sv
// Bit-serial radix-2 Montgomery modular multiplier: result = a*b*2^-WIDTH mod n.
// Consumes one multiplier bit per enabled cycle, then applies a single
// conditional subtraction. An even modulus is reported on err without iterating.
module mmm_serial_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_CORR = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH+1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH+1:0] b_ext;
    logic [WIDTH+1:0] n_ext;
    logic [WIDTH+1:0] sum_add;
    logic [WIDTH+1:0] sum_red;
    logic [WIDTH+1:0] acc_d;
    logic [WIDTH-1:0] result_d;

    // Montgomery step and final correction; acc < 2n keeps every sum below 4n,
    // so WIDTH+2 bits hold the full value before the halving shift.
    always_comb begin
        b_ext    = {2'b00, b_q};
        n_ext    = {2'b00, n_q};
        sum_add  = acc_q + (a_q[0] ? b_ext : '0);
        sum_red  = sum_add[0] ? (sum_add + n_ext) : sum_add;
        acc_d    = sum_red >> 1;
        result_d = WIDTH'((acc_q >= n_ext) ? (acc_q - n_ext) : acc_q);
    end

    // Control FSM with registered outputs; everything holds while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else if (ena) begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        n_q    <= n;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (n[0]) begin
                            err_q   <= 1'b0;
                            state_q <= S_ITER;
                        end else begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_ITER: begin
                    acc_q <= acc_d;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_CORR;
                    end
                end
                S_CORR: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    a_q      <= '0;
                    b_q      <= '0;
                    n_q      <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    result_q <= '0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_mmm_serial_core.sv
// Directed self-checking bench for mmm_serial_core (WIDTH=8).
// Expected products are hand-computed Montgomery values a*b*256^-1 mod n.
// Latency is counted in clock edges after the edge that accepts start:
// done is seen after edge WIDTH+1 (9) normally, after the accept edge (0) for an even modulus.
module tb_mmm_serial_core;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         ena;
    logic         start;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic [W-1:0] n_r;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    int n_checks;
    int n_fail;

    mmm_serial_core #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .start  (start),
        .a      (a_r),
        .b      (b_r),
        .n      (n_r),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, result, err and the return to idle.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] nv, input logic [W-1:0] exp_res,
                          input logic exp_err, input int exp_k);
        int k;
        @(negedge clk);
        start = 1'b1;
        a_r   = av;
        b_r   = bv;
        n_r   = nv;
        @(negedge clk);
        start = 1'b0;
        a_r   = W'($urandom);
        b_r   = W'($urandom);
        n_r   = W'($urandom);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, exp_k);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy_at_done"}, busy, 1);
        @(negedge clk);
        chk({tag, "_done_cleared"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int k;
        int en_edges;
        int seen;
        logic ph;

        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        ena   = 1'b1;
        start = 1'b0;
        a_r   = '0;
        b_r   = '0;
        n_r   = '0;

        // Reset values
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        // T1 / T2 / T3: 256^-1 mod 13 = 3, 256 = 1 mod 255
        run_op("t1_5x7", 8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 9);
        run_op("t2_12x12", 8'd12, 8'd12, 8'd13, 8'd3, 1'b0, 9);
        run_op("t2_1x1", 8'd1, 8'd1, 8'd13, 8'd3, 1'b0, 9);
        run_op("t2_0x9", 8'd0, 8'd9, 8'd13, 8'd0, 1'b0, 9);
        run_op("t2_12x1", 8'd12, 8'd1, 8'd13, 8'd10, 1'b0, 9);
        run_op("t3_254x254", 8'd254, 8'd254, 8'd255, 8'd1, 1'b0, 9);

        // T4: even modulus, err sticky in idle, cleared by the next accepted start
        run_op("t4_even", 8'd5, 8'd7, 8'd12, 8'd0, 1'b1, 0);
        repeat (2) @(negedge clk);
        chk("t4_err_sticky", err, 1);
        run_op("t4_clear", 8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 9);

        // T5: ena toggled every other cycle, extra starts while busy ignored
        @(negedge clk);
        start = 1'b1;
        a_r   = 8'd5;
        b_r   = 8'd7;
        n_r   = 8'd13;
        @(negedge clk);
        en_edges = 0;
        k  = 0;
        ph = 1'b0;
        while (done !== 1'b1 && k < 60) begin
            ena   = ph;
            start = 1'b1;
            a_r   = 8'd12;
            b_r   = 8'd12;
            n_r   = 8'd12;
            @(negedge clk);
            if (ph) en_edges++;
            ph = ~ph;
            k++;
        end
        chk("t5_enabled_edges", en_edges, 9);
        chk("t5_result", result, 1);
        chk("t5_err", err, 0);
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_done_held", done, 1);
        end
        // start still high on the edge where DONE returns to IDLE: not accepted
        ena = 1'b1;
        @(negedge clk);
        chk("t5_done_drop", done, 0);
        chk("t5_no_accept", busy, 0);
        start = 1'b0;
        @(negedge clk);
        chk("t5_still_idle", busy, 0);

        // T6: asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1;
        a_r   = 8'd5;
        b_r   = 8'd7;
        n_r   = 8'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_result", result, 0);
        chk("t6_rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        chk("t6_no_done", seen, 0);
        run_op("t6_after_rst", 8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
